module_disp_sched: RTL

Display scheduler for the calculator's 4-digit multiplexed 7-segment display. It shares the single display between two sources: live operand entry (units/tens digits from the operand display register) and a latched 4-digit BCD result. It time-multiplexes the digits at a fixed refresh rate and drives registered anode and segment lines straight to the board pins.

---
 rtl/module_disp_sched.sv | 66 ++++++
 1 files changed

// File: rtl/module_disp_sched.sv
// module_disp_sched: 4-digit 7-seg scan scheduler, operand entry vs latched BCD result (in: clk rst op_u op_d res res_valid new_entry; out: an seg mode)
module module_disp_sched #(
  parameter int REFRESH_CYCLES = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_u,
  input  logic [3:0]  op_d,
  input  logic [15:0] res,
  input  logic        res_valid,
  input  logic        new_entry,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        mode
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  typedef enum logic {ENTRY = 1'b0, RESULT = 1'b1} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [15:0] res_q;
  logic [3:0] dig;
  logic blank, tick;
  logic [6:0] dec, seg_n;
  assign tick = cnt == CW'(REFRESH_CYCLES - 1);
  assign mode = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ENTRY;
      cnt <= '0;
      idx <= '0;
      res_q <= '0;
      an <= 4'hf;
      seg <= 7'h7f;
    end else begin
      st <= nxt;
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= idx + {1'b0, tick};
      if (res_valid) res_q <= res;
      an <= ~(4'b0001 << idx);
      seg <= seg_n;
    end
  end
  always_comb begin
    nxt = res_valid ? RESULT : new_entry ? ENTRY : st;
    dig = (st == ENTRY) ? (idx[0] ? op_d : op_u) : res_q[{idx, 2'b00} +: 4];
    blank = (st == ENTRY) ? idx[1] :
            (idx == 2'd3) ? (res_q[15:12] == 4'd0) :
            (idx == 2'd2) ? (res_q[15:8] == 8'd0) :
            (idx == 2'd1) ? (res_q[15:4] == 12'd0) : 1'b0;
    case (dig)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
    seg_n = blank ? 7'h7f : dec;
  end
endmodule
